// File: rtl/robo_sequenciador_if.sv
// Sequencer bus: mission control, robot FSM commands, actuator handshake and status.
interface robo_sequenciador_if;
    logic       start;
    logic [7:0] qtd_movimentos;
    logic       avancar;
    logic       girar;
    logic       remover;
    logic       act_ack;
    logic       robo_step;
    logic       act_valid;
    logic [1:0] act_cmd;
    logic [7:0] mov_count;
    logic       busy;
    logic       done;
    logic       trapped;
    logic       erro;

    modport master (
        input  start, qtd_movimentos, avancar, girar, remover, act_ack,
        output robo_step, act_valid, act_cmd, mov_count, busy, done, trapped, erro
    );

    modport slave (
        output start, qtd_movimentos, avancar, girar, remover, act_ack,
        input  robo_step, act_valid, act_cmd, mov_count, busy, done, trapped, erro
    );
endinterface

// File: rtl/robo_sequenciador.sv
// Mission sequencer: steps the robot FSM, forwards each command over valid/ack, tracks budget and traps.
// Optional actuator timeout enabled by defining ROBO_SEQ_TIMEOUT_EN.
module robo_sequenciador #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input logic                 clock,
    input logic                 reset,
    robo_sequenciador_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_STEP,
        S_CAPTURE,
        S_ISSUE,
        S_DONE,
        S_TRAPPED,
        S_ERRO
    } state_t;

    localparam logic [1:0] CMD_NONE = 2'b00;
    localparam logic [1:0] CMD_ADV  = 2'b01;
    localparam logic [1:0] CMD_TURN = 2'b10;
    localparam logic [1:0] CMD_REM  = 2'b11;

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be in 1..255");
    end

    state_t     r_state;
    logic [7:0] r_budget;
    logic [7:0] r_mov_count;
    logic [2:0] r_turns;
    logic [1:0] r_cmd;
    logic       r_valid;
    logic       r_step;
    logic       r_busy;
    logic       r_done;
    logic       r_trapped;

`ifdef ROBO_SEQ_TIMEOUT_EN
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0] r_tmo;
    logic       r_erro;
`endif

    logic [1:0] w_cmd;
    logic [7:0] w_cnt_next;
    logic [2:0] w_turns_after;
    logic       w_step_end;

    // remover outranks girar, which outranks avancar
    always_comb begin
        w_cmd = CMD_NONE;
        if (bus.remover) begin
            w_cmd = CMD_REM;
        end else if (bus.girar) begin
            w_cmd = CMD_TURN;
        end else if (bus.avancar) begin
            w_cmd = CMD_ADV;
        end
    end

    always_comb begin
        w_turns_after = r_turns;
        if (r_state == S_ISSUE) begin
            if (r_cmd == CMD_TURN) begin
                w_turns_after = r_turns + 3'd1;
            end else if (r_cmd == CMD_ADV) begin
                w_turns_after = 3'd0;
            end
        end
    end

    assign w_cnt_next = r_mov_count + 8'd1;
    assign w_step_end = ((r_state == S_CAPTURE) && (w_cmd == CMD_NONE)) ||
                        ((r_state == S_ISSUE) && bus.act_ack);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_budget    <= 8'd0;
            r_mov_count <= 8'd0;
            r_turns     <= 3'd0;
            r_cmd       <= CMD_NONE;
            r_valid     <= 1'b0;
            r_step      <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_trapped   <= 1'b0;
`ifdef ROBO_SEQ_TIMEOUT_EN
            r_tmo       <= 8'd0;
            r_erro      <= 1'b0;
`endif
        end else begin
            r_step <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE, S_TRAPPED, S_ERRO: begin
                    if (bus.start) begin
                        r_budget    <= bus.qtd_movimentos;
                        r_mov_count <= 8'd0;
                        r_turns     <= 3'd0;
                        r_trapped   <= 1'b0;
`ifdef ROBO_SEQ_TIMEOUT_EN
                        r_erro      <= 1'b0;
`endif
                        if (bus.qtd_movimentos == 8'd0) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= S_STEP;
                            r_step  <= 1'b1;
                            r_busy  <= 1'b1;
                            r_done  <= 1'b0;
                        end
                    end
                end
                S_STEP: begin
                    r_state <= S_CAPTURE;
                end
                S_CAPTURE: begin
                    if (w_cmd != CMD_NONE) begin
                        r_cmd   <= w_cmd;
                        r_valid <= 1'b1;
                        r_state <= S_ISSUE;
`ifdef ROBO_SEQ_TIMEOUT_EN
                        r_tmo   <= 8'd0;
`endif
                    end
                end
                S_ISSUE: begin
                    if (bus.act_ack) begin
                        r_valid <= 1'b0;
                        r_cmd   <= CMD_NONE;
`ifdef ROBO_SEQ_TIMEOUT_EN
                    end else if (r_tmo == TMO_LAST) begin
                        // abandoned request: the step is not counted
                        r_valid <= 1'b0;
                        r_cmd   <= CMD_NONE;
                        r_busy  <= 1'b0;
                        r_erro  <= 1'b1;
                        r_state <= S_ERRO;
                    end else begin
                        r_tmo <= r_tmo + 8'd1;
`endif
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase

            // end-of-step bookkeeping shared by no-op captures and acknowledged commands
            if (w_step_end) begin
                r_mov_count <= w_cnt_next;
                r_turns     <= w_turns_after;
                if (w_turns_after == 3'd4) begin
                    r_state   <= S_TRAPPED;
                    r_trapped <= 1'b1;
                    r_busy    <= 1'b0;
                end else if (w_cnt_next == r_budget) begin
                    r_state <= S_DONE;
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                end else begin
                    r_state <= S_STEP;
                    r_step  <= 1'b1;
                end
            end
        end
    end

    assign bus.robo_step = r_step;
    assign bus.act_valid = r_valid;
    assign bus.act_cmd   = r_cmd;
    assign bus.mov_count = r_mov_count;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.trapped   = r_trapped;
`ifdef ROBO_SEQ_TIMEOUT_EN
    assign bus.erro      = r_erro;
`else
    assign bus.erro      = 1'b0;
`endif

endmodule

// File: tb/tb_robo_sequenciador.sv
// Scoreboard bench for robo_sequenciador: robot/actuator models push expected commands, monitor pops them.
module tb_robo_sequenciador;

    logic clock = 1'b0;
    logic reset;

    always #5 clock = ~clock;

    robo_sequenciador_if bus();

    robo_sequenciador #(.TIMEOUT_CYCLES(16)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [1:0] exp_q[$];
    logic [2:0] pat_q[$];
    logic [2:0] pat_def    = 3'b000;
    logic [2:0] robo_cur   = 3'b000;
    int         ack_mode   = 1;
    int         ack_credit = 0;
    int         cyc        = 0;
    int         step_pulses = 0;
    int         hs_count   = 0;
    int         hs_base    = 0;
    int         last_hs    = 0;
    bit         gap_chk    = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [1:0] decode(input logic [2:0] p);
        if (p[2]) return 2'b11;
        if (p[1]) return 2'b10;
        if (p[0]) return 2'b01;
        return 2'b00;
    endfunction

    // robot FSM model, actuator model and scoreboard monitor, all away from the rising edge
    always @(negedge clock) begin
        #3;
        cyc++;
        if (bus.robo_step === 1'b1) begin
            step_pulses++;
            if (pat_q.size() > 0) robo_cur = pat_q.pop_front();
            else robo_cur = pat_def;
            if (decode(robo_cur) != 2'b00) exp_q.push_back(decode(robo_cur));
        end
        {bus.remover, bus.girar, bus.avancar} = robo_cur;
        case (ack_mode)
            0: bus.act_ack = 1'b0;
            2: bus.act_ack = (bus.act_valid === 1'b1) ? ($urandom_range(0, 2) == 0) : 1'($urandom_range(0, 1));
            3: begin
                bus.act_ack = (bus.act_valid === 1'b1) && (ack_credit > 0);
                if (bus.act_ack) ack_credit--;
            end
            default: bus.act_ack = 1'b1;
        endcase
        if (bus.act_valid === 1'b1 && bus.act_ack === 1'b1) begin
            if (exp_q.size() == 0) check("sb_underflow", 0, 1);
            else check("act_cmd", bus.act_cmd, exp_q.pop_front());
            if (gap_chk && (hs_count - hs_base) > 0) check("hs_gap", cyc - last_hs, 3);
            hs_count++;
            last_hs = cyc;
        end else if (bus.act_valid === 1'b0) begin
            check("cmd_idle", bus.act_cmd, 0);
        end
    end

    task automatic sync();
        @(negedge clock);
        #2;
    endtask

    task automatic do_start(input int budget);
        bus.qtd_movimentos = 8'(budget);
        bus.start = 1'b1;
        sync();
        bus.start = 1'b0;
    endtask

    task automatic wait_flag(input int max, output int cycles);
        cycles = 0;
        while (!(bus.done || bus.trapped || bus.erro) && cycles < max) begin
            sync();
            cycles++;
        end
        check("flag_seen", 32'(bus.done || bus.trapped || bus.erro), 1);
    endtask

    task automatic wait_valid(input int max);
        int n = 0;
        while (bus.act_valid !== 1'b1 && n < max) begin
            sync();
            n++;
        end
        check("valid_seen", bus.act_valid, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got 0 expected 1");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cycles, s0, h0, n, mov_exp, hs_exp, t;
        logic trap_exp;
        logic [2:0] p[8];

        reset = 1'b1;
        bus.start = 1'b0;
        bus.qtd_movimentos = 8'd0;
        repeat (3) sync();
        check("rst_step", bus.robo_step, 0);
        check("rst_valid", bus.act_valid, 0);
        check("rst_cmd", bus.act_cmd, 0);
        check("rst_mov", bus.mov_count, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_flags", {bus.done, bus.trapped, bus.erro}, 0);
        reset = 1'b0;
        sync();

        // budget 3, constant advance, ack always high
        pat_def = 3'b001; ack_mode = 1; hs_base = hs_count; gap_chk = 1'b1;
        s0 = step_pulses; h0 = hs_count;
        do_start(3);
        check("t1_step", bus.robo_step, 1);
        check("t1_busy", bus.busy, 1);
        wait_flag(50, cycles);
        gap_chk = 1'b0;
        check("t1_cycles", cycles, 9);
        check("t1_done", bus.done, 1);
        check("t1_trapped", bus.trapped, 0);
        check("t1_mov", bus.mov_count, 3);
        check("t1_steps", step_pulses - s0, 3);
        check("t1_hs", hs_count - h0, 3);
        check("t1_busy_end", bus.busy, 0);
        check("t1_sb_empty", exp_q.size(), 0);

        // budget 10, constant turn: trapped after four turns
        pat_def = 3'b010; h0 = hs_count;
        do_start(10);
        wait_flag(80, cycles);
        check("t2_cycles", cycles, 12);
        check("t2_trapped", bus.trapped, 1);
        check("t2_done", bus.done, 0);
        check("t2_mov", bus.mov_count, 4);
        check("t2_hs", hs_count - h0, 4);
        check("t2_sb_empty", exp_q.size(), 0);

        // remove between turns leaves the turn count alone
        pat_q = '{3'b010, 3'b010, 3'b010, 3'b111, 3'b010};
        pat_def = 3'b001; h0 = hs_count;
        do_start(6);
        wait_flag(80, cycles);
        check("t3_cycles", cycles, 15);
        check("t3_trapped", bus.trapped, 1);
        check("t3_mov", bus.mov_count, 5);
        check("t3_hs", hs_count - h0, 5);
        check("t3_sb_empty", exp_q.size(), 0);

        // no-op step in the middle
        pat_q = '{3'b001, 3'b000, 3'b001};
        h0 = hs_count;
        do_start(3);
        wait_flag(80, cycles);
        check("t4_cycles", cycles, 8);
        check("t4_done", bus.done, 1);
        check("t4_mov", bus.mov_count, 3);
        check("t4_hs", hs_count - h0, 2);

        // budget 0
        s0 = step_pulses;
        do_start(0);
        wait_flag(10, cycles);
        check("t5_cycles", cycles, 0);
        check("t5_done", bus.done, 1);
        check("t5_busy", bus.busy, 0);
        check("t5_mov", bus.mov_count, 0);
        sync(); sync();
        check("t5_steps", step_pulses - s0, 0);

        // random commands, random ack latency, ack noise outside ISSUE
        for (int r = 0; r < 3; r++) begin
            t = 0; mov_exp = 0; hs_exp = 0; trap_exp = 1'b0;
            for (int i = 0; i < 8; i++) begin
                p[i] = 3'($urandom_range(0, 7));
                pat_q.push_back(p[i]);
            end
            for (int i = 0; i < 8; i++) begin
                mov_exp++;
                if (decode(p[i]) != 2'b00) hs_exp++;
                if (decode(p[i]) == 2'b10) t++;
                else if (decode(p[i]) == 2'b01) t = 0;
                if (t == 4) begin
                    trap_exp = 1'b1;
                    break;
                end
            end
            ack_mode = 2; h0 = hs_count;
            do_start(8);
            wait_flag(600, cycles);
            check("t6_trapped", bus.trapped, 32'(trap_exp));
            check("t6_done", bus.done, 32'(!trap_exp));
            check("t6_mov", bus.mov_count, mov_exp);
            check("t6_hs", hs_count - h0, hs_exp);
            check("t6_sb_empty", exp_q.size(), 0);
            ack_mode = 1;
            pat_q.delete();
        end

        // reset while a request is pending with two steps done
        pat_def = 3'b001; ack_credit = 2; ack_mode = 3;
        do_start(10);
        n = 0;
        while (!(bus.act_valid === 1'b1 && bus.mov_count == 8'd2) && n < 40) begin
            sync();
            n++;
        end
        check("t7_pending", 32'(bus.act_valid === 1'b1 && bus.mov_count == 8'd2), 1);
        reset = 1'b1;
        sync();
        check("t7_valid", bus.act_valid, 0);
        check("t7_mov", bus.mov_count, 0);
        check("t7_busy", bus.busy, 0);
        check("t7_step", bus.robo_step, 0);
        check("t7_flags", {bus.done, bus.trapped, bus.erro}, 0);
        reset = 1'b0;
        exp_q.delete();
        sync();

        // actuator never acknowledges
        ack_mode = 0;
        do_start(5);
        wait_valid(10);
`ifdef ROBO_SEQ_TIMEOUT_EN
        n = 0;
        while (bus.act_valid === 1'b1 && n < 40) begin
            n++;
            sync();
        end
        check("t8_valid_cycles", n, 16);
        check("t8_erro", bus.erro, 1);
        check("t8_valid", bus.act_valid, 0);
        check("t8_mov", bus.mov_count, 0);
        check("t8_busy", bus.busy, 0);
        check("t8_done", bus.done, 0);
`else
        repeat (100) sync();
        check("t8_valid", bus.act_valid, 1);
        check("t8_erro", bus.erro, 0);
        check("t8_busy", bus.busy, 1);
        check("t8_mov", bus.mov_count, 0);
`endif
        reset = 1'b1;
        sync();
        reset = 1'b0;
        exp_q.delete();

        // restart after abort behaves like a fresh mission
        ack_mode = 1; pat_def = 3'b001; h0 = hs_count;
        do_start(2);
        wait_flag(40, cycles);
        check("t9_cycles", cycles, 6);
        check("t9_done", bus.done, 1);
        check("t9_mov", bus.mov_count, 2);
        check("t9_hs", hs_count - h0, 2);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/robo_sequenciador.md
# robo_sequenciador

Mission sequencer for the wall-following robot: steps the robot FSM one decision at a time and forwards each decoded command (advance, turn, remove) to the actuator interface over a valid/ack handshake. It counts executed steps against a move budget and detects a trapped robot (four consecutive turns with no advance). It sits between the robot FSM outputs (`avancar`, `girar`, `remover`) and the physical/bench actuator model, and replaces free-running stepping of the robot.

## Interface
- `TIMEOUT_CYCLES`, default 16: maximum cycles `act_valid` may stay high without `act_ack` (used only with `ROBO_SEQ_TIMEOUT_EN`); legal range 1..255.
- `clock`  in  1  single clock, rising edge.
- `reset`  in  1  synchronous, active-high; one clock, synchronous active-high reset for the whole block.
- `start`  in  1  begin a mission; sampled only in IDLE, DONE, TRAPPED, ERRO.
- `qtd_movimentos`  in  8  move budget, latched on accepted `start`.
- `avancar`, `girar`, `remover`  in  1 each  command outputs of the robot FSM.
- `act_ack`  in  1  actuator completion, sampled on rising edge.
- `robo_step`  out  1  one-cycle enable that advances the robot FSM.
- `act_valid`  out  1  actuator request.
- `act_cmd`  out  2  01 advance, 10 turn, 11 remove; 00 whenever `act_valid`=0.
- `mov_count`  out  8  steps completed in the current mission.
- `busy`, `done`, `trapped`, `erro`  out  1 each  status.

## Operation
- States: IDLE, STEP, CAPTURE, ISSUE, DONE, TRAPPED, ERRO.
- IDLE: on `start`=1, latch budget, clear `mov_count` and turn counter. Go to DONE if the budget is 0, else go to STEP.
- STEP: `robo_step`=1 for exactly this cycle → CAPTURE.
- CAPTURE: sample robot commands. Priority is `remover` > `girar` > `avancar`.
  - A command is present: load `act_cmd` → ISSUE.
  - No command present: no-op step; increment `mov_count` and run the end-of-step check.
- ISSUE: `act_valid`=1 with `act_cmd` held stable until `act_ack`=1 is sampled. On that edge, `act_valid`/`act_cmd` drop, `mov_count` increments, and the turn counter updates:
  - turn: +1
  - advance: clear to 0
  - remove: unchanged
- End-of-step check, in order:
  - turn counter = 4 → TRAPPED;
  - else `mov_count` = budget → DONE;
  - else → STEP.
- DONE / TRAPPED / ERRO: the matching flag is held at 1. `start`=1 restarts the mission exactly as from IDLE.
- `busy`=1 in STEP, CAPTURE, ISSUE.
- `act_ack` outside ISSUE is ignored. `start` while busy is ignored.
- `mov_count` never wraps: the budget is at most 255 and counting stops at the budget.

## Timing
- Reset values: state IDLE; all outputs 0; `act_cmd`=00; `mov_count`=0; turn counter 0.
- Reset mid-mission (any state): on the reset edge, `act_valid` and `robo_step` drop and all counters clear; no partial step is counted.
- `start` sampled at edge k → `robo_step` high during cycle k+1 → commands sampled at edge k+2 → `act_valid` high from k+2.
- A commanded step with `act_ack` already high takes 3 cycles (STEP, CAPTURE, ISSUE). A no-op step takes 2 cycles.
- `act_ack` may be high in the first ISSUE cycle; `act_valid` is then high for exactly one cycle.
- The flag for DONE, TRAPPED or ERRO rises on the edge after the final ack/capture.

## Configuration
- `ROBO_SEQ_TIMEOUT_EN` defined:
  - A cycle counter runs while in ISSUE.
  - If `act_ack` is still 0 after `TIMEOUT_CYCLES` cycles of `act_valid`, go to ERRO: `erro`=1, `act_valid`=0, and the step is not counted.
- Not defined:
  - ISSUE waits indefinitely for `act_ack`.
  - `erro` is tied to 0 and ERRO is unreachable.

## Test plan
- Budget 3, `avancar`=1 constant, `act_ack`=1 constant → three `act_valid` pulses with `act_cmd`=01, 3 cycles apart; `done`=1 with `mov_count`=3; `trapped`=0.
- Budget 10, `girar`=1 constant → four turns, then `trapped`=1 with `mov_count`=4, `done`=0.
- `remover`=`avancar`=`girar`=1 together → `act_cmd`=11; turn counter unchanged.
- Budget 0, `start` pulse → `done`=1 one cycle later; `robo_step` never asserted.
- Reset asserted while `act_valid`=1 with `mov_count`=2 → after that edge, `act_valid`=0, `mov_count`=0, `busy`=0, state IDLE.
- `act_ack` held 0, `TIMEOUT_CYCLES`=16:
  - with `ROBO_SEQ_TIMEOUT_EN`, `erro`=1 and `act_valid`=0 after 16 valid cycles;
  - without it, `act_valid` is still 1 after 100 cycles and `erro`=0.
